// File: rtl/pkg_commit_agg.sv
// Commit-aggregator side definitions: issue FSM states and O_Err bit map.
package pkg_commit_agg;

   typedef enum logic {
      ISSUE_IDLE     = 1'b0,
      ISSUE_DISPATCH = 1'b1
   } issue_fsm_t;

   localparam int unsigned ERR_W          = 3;
   localparam int unsigned ERR_ORDER      = 0;  // commit out of order / unexpected
   localparam int unsigned ERR_EMPTY_MASK = 1;  // request with no TPU enabled
   localparam int unsigned ERR_TIMEOUT    = 2;  // dispatch watchdog expired

endpackage

// File: rtl/pkg_mpu.sv
// MPU-side shared types: issue number carried between sequencer,
// dispatch controller and commit aggregator.
package pkg_mpu;

   localparam int unsigned MPU_ISSUE_NO_W = 4;

   typedef logic [MPU_ISSUE_NO_W-1:0] mpu_issue_no_t;

endpackage

// File: rtl/issue_credit_cnt.sv
// Up/down saturating credit counter. An increment is ignored when full and a
// decrement is ignored when empty; both in one cycle cancel out.
module issue_credit_cnt #(
   parameter int unsigned MAX_CNT = 4,
   parameter int unsigned CNT_W   = $clog2(MAX_CNT + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             up, dn;

   assign full_o  = (cnt_q == CNT_W'(MAX_CNT));
   assign empty_o = (cnt_q == '0);
   assign cnt_o   = cnt_q;

   // next count: saturate at both ends
   always_comb begin
      up    = inc_i & ~full_o;
      dn    = dec_i & ~empty_o;
      cnt_d = cnt_q;
      if (up & ~dn)
         cnt_d = cnt_q + 1'b1;
      else if (dn & ~up)
         cnt_d = cnt_q - 1'b1;
   end

   // count register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/issue_dispatch_ctrl.sv
// Issue dispatch controller: accepts one issue from the MPU sequencer,
// registers it with the commit aggregator, then hands it to every enabled TPU
// with independent per-TPU handshakes. Tracks outstanding issues as credits
// and checks that commits come back in issue order.
// Optional feature macro: ISSUE_TIMEOUT_EN (dispatch watchdog, O_Err[2]).
module issue_dispatch_ctrl
   import pkg_mpu::*, pkg_commit_agg::*;
#(
   parameter  int unsigned NUM_TPU     = 1,
   parameter  int unsigned BUFF_SIZE   = 4,
   parameter  int unsigned TIMEOUT_CYC = 1024,
   localparam int unsigned CNT_W       = $clog2(BUFF_SIZE + 1)
) (
   input  logic               clock,
   input  logic               reset,          // async, active-low
   input  logic               I_Req,
   input  logic [NUM_TPU-1:0] I_En_TPU,
   output logic               O_Ack,
   output logic [NUM_TPU-1:0] O_Issue_Valid,
   output mpu_issue_no_t      O_Issue_No,
   input  logic [NUM_TPU-1:0] I_TPU_Ready,
   output logic               O_Agg_Req,
   output logic [NUM_TPU-1:0] O_Agg_En_TPU,
   input  logic               I_Agg_Full,
   input  logic               I_Commit_Req,
   input  mpu_issue_no_t      I_Commit_No,
   output logic [CNT_W-1:0]   O_Outstanding,
   output logic               O_Busy,
   output logic [ERR_W-1:0]   O_Err
);

   issue_fsm_t         state_q, state_d;
   mpu_issue_no_t      next_no_q, next_no_d;
   mpu_issue_no_t      oldest_no_q, oldest_no_d;
   logic [NUM_TPU-1:0] mask_q, mask_d;
   logic [NUM_TPU-1:0] done_q, done_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic [NUM_TPU-1:0] valid, hs;
   logic               accept, reject, all_done, timeout, wd_expired;
   logic               cred_full, cred_empty;
   logic [CNT_W-1:0]   cred_cnt;

   // Outstanding issues: +1 on accept, -1 on any commit while non-empty
   issue_credit_cnt #(
      .MAX_CNT (BUFF_SIZE),
      .CNT_W   (CNT_W)
   ) u_credit (
      .clk_i   (clock),
      .rst_ni  (reset),
      .inc_i   (accept),
      .dec_i   (I_Commit_Req),
      .cnt_o   (cred_cnt),
      .full_o  (cred_full),
      .empty_o (cred_empty)
   );

`ifdef ISSUE_TIMEOUT_EN
   localparam int unsigned WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [WD_W-1:0] wd_q, wd_d;

   assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYC - 1));

   // watchdog: restart on DISPATCH entry, count every DISPATCH cycle
   always_comb begin
      wd_d = wd_q;
      if (accept)
         wd_d = '0;
      else if (state_q == ISSUE_DISPATCH)
         wd_d = wd_q + 1'b1;
   end

   // watchdog register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) wd_q <= '0;
      else        wd_q <= wd_d;
   end
`else
   assign wd_expired = 1'b0;
`endif

   // FSM next state, handshake tracking and issue-number advance
   always_comb begin
      state_d   = state_q;
      next_no_d = next_no_q;
      mask_d    = mask_q;
      done_d    = done_q;
      accept    = 1'b0;
      reject    = 1'b0;
      valid     = '0;
      hs        = '0;
      all_done  = 1'b0;
      timeout   = 1'b0;
      case (state_q)
         ISSUE_IDLE: begin
            if (I_Req) begin
               if (~|I_En_TPU) begin
                  reject = 1'b1;
               end else if (~I_Agg_Full & ~cred_full) begin
                  // aggregator entry is registered in this same cycle, so it
                  // exists before any TPU can see the issue
                  accept  = 1'b1;
                  mask_d  = I_En_TPU;
                  done_d  = '0;
                  state_d = ISSUE_DISPATCH;
               end
            end
         end
         ISSUE_DISPATCH: begin
            valid    = mask_q & ~done_q;
            hs       = valid & I_TPU_Ready;
            done_d   = done_q | hs;
            all_done = (done_d == mask_q);
            timeout  = ~all_done & wd_expired;
            if (all_done | timeout) begin
               // on timeout the credit stays held; only reset recovers it
               next_no_d = next_no_q + 1'b1;
               state_d   = ISSUE_IDLE;
            end
         end
      endcase
   end

   // commit order check and sticky error collection
   always_comb begin
      oldest_no_d = oldest_no_q;
      err_d       = err_q;
      if (reject)  err_d[ERR_EMPTY_MASK] = 1'b1;
      if (timeout) err_d[ERR_TIMEOUT]    = 1'b1;
      if (I_Commit_Req) begin
         if (cred_empty) begin
            err_d[ERR_ORDER] = 1'b1;
         end else begin
            // a wrong number still retires the oldest credit
            if (I_Commit_No != oldest_no_q) err_d[ERR_ORDER] = 1'b1;
            oldest_no_d = oldest_no_q + 1'b1;
         end
      end
   end

   // state registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ISSUE_IDLE;
         next_no_q   <= '0;
         oldest_no_q <= '0;
         mask_q      <= '0;
         done_q      <= '0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         next_no_q   <= next_no_d;
         oldest_no_q <= oldest_no_d;
         mask_q      <= mask_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign O_Ack         = accept | reject;
   assign O_Agg_Req     = accept;
   assign O_Agg_En_TPU  = accept ? I_En_TPU : '0;
   assign O_Issue_Valid = valid;
   assign O_Issue_No    = next_no_q;   // held through DISPATCH, advances on exit
   assign O_Outstanding = cred_cnt;
   assign O_Busy        = (state_q == ISSUE_DISPATCH);
   assign O_Err         = err_q;

endmodule

// File: tb/tb_issue_dispatch_ctrl.sv
// Bench for issue_dispatch_ctrl: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_issue_dispatch_ctrl;

   localparam int NT = 4;
   localparam int BS = 4;
   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req, agg_full, cm_req;
   logic [3:0] en, rdy, cm_no;
   logic       ack, agg_req, busy;
   logic [3:0] ivld, ino, agg_en;
   logic [2:0] outst, err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   issue_dispatch_ctrl #(
      .NUM_TPU     (NT),
      .BUFF_SIZE   (BS),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clock         (clk),
      .reset         (rst_n),
      .I_Req         (req),
      .I_En_TPU      (en),
      .O_Ack         (ack),
      .O_Issue_Valid (ivld),
      .O_Issue_No    (ino),
      .I_TPU_Ready   (rdy),
      .O_Agg_Req     (agg_req),
      .O_Agg_En_TPU  (agg_en),
      .I_Agg_Full    (agg_full),
      .I_Commit_Req  (cm_req),
      .I_Commit_No   (cm_no),
      .O_Outstanding (outst),
      .O_Busy        (busy),
      .O_Err         (err)
   );

   // {ack, agg_req, agg_en, valid, issue_no, outstanding, busy, err}
   function automatic logic [20:0] obs();
      return {ack, agg_req, agg_en, ivld, ino, outst, busy, err};
   endfunction

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic do_reset();
      req = 0; en = 0; rdy = 0; agg_full = 0; cm_req = 0; cm_no = 0;
      @(negedge clk);
      rst_n = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_reset();
      logic [20:0] ev;
      req = 0; en = 0; rdy = 0; agg_full = 0; cm_req = 0; cm_no = 0;
      rst_n = 0;
      nxt(); #1;
      ev = '0;
      checks++; if (obs() !== ev) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs(), ev); end
      nxt();
      rst_n = 1;
   endtask

   // mask 1011 with all ready: one dispatch cycle, then next number
   task automatic test_all_ready();
      logic [20:0] ev;
      req = 1; en = 4'b1011; rdy = 4'b1111; #1;
      ev = {1'b1, 1'b1, 4'b1011, 4'b0000, 4'd0, 3'd0, 1'b0, 3'b000};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL all_ready_accept got=%h exp=%h", obs(), ev); end
      nxt(); req = 0; #1;
      ev = {1'b0, 1'b0, 4'b0000, 4'b1011, 4'd0, 3'd1, 1'b1, 3'b000};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL all_ready_dispatch got=%h exp=%h", obs(), ev); end
      nxt(); #1;
      ev = {1'b0, 1'b0, 4'b0000, 4'b0000, 4'd1, 3'd1, 1'b0, 3'b000};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL all_ready_idle got=%h exp=%h", obs(), ev); end
   endtask

   // mask 1011, ready bits 0,3,1 at dispatch cycles 1,2,4
   task automatic test_staggered();
      logic [20:0] ev;
      logic [3:0]  vt [4];
      logic [3:0]  rt [4];
      vt = '{4'b1011, 4'b1010, 4'b0010, 4'b0010};
      rt = '{4'b0001, 4'b1000, 4'b1101, 4'b0010};
      nxt();
      req = 1; en = 4'b1011; rdy = 4'b0000; #1;
      ev = {1'b1, 1'b1, 4'b1011, 4'b0000, 4'd1, 3'd1, 1'b0, 3'b000};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL stag_accept got=%h exp=%h", obs(), ev); end
      nxt(); req = 0;
      for (int k = 0; k < 4; k++) begin
         rdy = rt[k]; #1;
         ev = {1'b0, 1'b0, 4'b0000, vt[k], 4'd1, 3'd2, 1'b1, 3'b000};
         checks++; if (obs() !== ev) begin failures++; $display("FAIL stag_cyc%0d got=%h exp=%h", k + 1, obs(), ev); end
         nxt();
      end
      rdy = 0; #1;
      ev = {1'b0, 1'b0, 4'b0000, 4'b0000, 4'd2, 3'd2, 1'b0, 3'b000};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL stag_idle got=%h exp=%h", obs(), ev); end
   endtask

   // credit limit: four accepted, fifth stalls until a commit frees a slot
   task automatic test_credit();
      logic [20:0] ev;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         req = 1; en = 4'b0001; rdy = 4'b0001; #1;
         ev = {1'b1, 1'b1, 4'b0001, 4'b0000, 4'(i), 3'(i), 1'b0, 3'b000};
         checks++; if (obs() !== ev) begin failures++; $display("FAIL credit_acc%0d got=%h exp=%h", i, obs(), ev); end
         nxt(); req = 0; #1;
         ev = {1'b0, 1'b0, 4'b0000, 4'b0001, 4'(i), 3'(i + 1), 1'b1, 3'b000};
         checks++; if (obs() !== ev) begin failures++; $display("FAIL credit_disp%0d got=%h exp=%h", i, obs(), ev); end
         nxt();
      end
      req = 1;
      for (int k = 0; k < 3; k++) begin
         #1;
         ev = {1'b0, 1'b0, 4'b0000, 4'b0000, 4'd4, 3'd4, 1'b0, 3'b000};
         checks++; if (obs() !== ev) begin failures++; $display("FAIL credit_stall%0d got=%h exp=%h", k, obs(), ev); end
         nxt();
      end
      cm_req = 1; cm_no = 0; #1;
      ev = {1'b0, 1'b0, 4'b0000, 4'b0000, 4'd4, 3'd4, 1'b0, 3'b000};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL credit_commit got=%h exp=%h", obs(), ev); end
      nxt(); cm_req = 0; #1;
      ev = {1'b1, 1'b1, 4'b0001, 4'b0000, 4'd4, 3'd3, 1'b0, 3'b000};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL credit_fifth got=%h exp=%h", obs(), ev); end
      nxt(); req = 0; #1;
      ev = {1'b0, 1'b0, 4'b0000, 4'b0001, 4'd4, 3'd4, 1'b1, 3'b000};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL credit_fifth_disp got=%h exp=%h", obs(), ev); end
      nxt();
   endtask

   // accept+commit same cycle, wrong-order commit, commit with nothing outstanding
   task automatic test_same_cycle_and_order();
      logic [20:0] ev;
      do_reset();
      req = 1; en = 4'b0001; rdy = 4'b0001; #1;
      ev = {1'b1, 1'b1, 4'b0001, 4'b0000, 4'd0, 3'd0, 1'b0, 3'b000};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL sc_acc0 got=%h exp=%h", obs(), ev); end
      nxt(); req = 0; #1;
      nxt();
      req = 1; cm_req = 1; cm_no = 0; #1;
      ev = {1'b1, 1'b1, 4'b0001, 4'b0000, 4'd1, 3'd1, 1'b0, 3'b000};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL sc_acc_commit got=%h exp=%h", obs(), ev); end
      nxt(); req = 0; cm_req = 0; #1;
      ev = {1'b0, 1'b0, 4'b0000, 4'b0001, 4'd1, 3'd1, 1'b1, 3'b000};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL sc_unchanged got=%h exp=%h", obs(), ev); end
      nxt(); cm_req = 1; cm_no = 2; #1;
      ev = {1'b0, 1'b0, 4'b0000, 4'b0000, 4'd2, 3'd1, 1'b0, 3'b000};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL sc_before_bad got=%h exp=%h", obs(), ev); end
      nxt(); cm_req = 0; #1;
      ev = {1'b0, 1'b0, 4'b0000, 4'b0000, 4'd2, 3'd0, 1'b0, 3'b001};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL sc_bad_order got=%h exp=%h", obs(), ev); end
      nxt(); cm_req = 1; cm_no = 1;
      nxt(); cm_req = 0; #1;
      ev = {1'b0, 1'b0, 4'b0000, 4'b0000, 4'd2, 3'd0, 1'b0, 3'b001};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL sc_empty_commit got=%h exp=%h", obs(), ev); end
      nxt();
   endtask

   // empty mask: ack without allocation, sticky err[1]
   task automatic test_empty_mask();
      logic [20:0] ev;
      do_reset();
      req = 1; en = 4'b0000; #1;
      ev = {1'b1, 1'b0, 4'b0000, 4'b0000, 4'd0, 3'd0, 1'b0, 3'b000};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL em_ack got=%h exp=%h", obs(), ev); end
      nxt(); req = 0; #1;
      ev = {1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0, 3'd0, 1'b0, 3'b010};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL em_err got=%h exp=%h", obs(), ev); end
      nxt(); req = 1; en = 4'b0100; rdy = 4'b0100; #1;
      ev = {1'b1, 1'b1, 4'b0100, 4'b0000, 4'd0, 3'd0, 1'b0, 3'b010};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL em_next_no got=%h exp=%h", obs(), ev); end
      nxt(); req = 0; #1;
      nxt();
   endtask

   // one TPU never ready: watchdog (if built) then async reset mid-DISPATCH
   task automatic test_stuck_and_reset();
      logic [20:0] ev;
      do_reset();
      req = 1; en = 4'b0011; rdy = 4'b0001; #1;
      ev = {1'b1, 1'b1, 4'b0011, 4'b0000, 4'd0, 3'd0, 1'b0, 3'b000};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL stuck_accept got=%h exp=%h", obs(), ev); end
      nxt(); req = 0;
      for (int k = 1; k <= TO; k++) begin
         #1;
         ev = {1'b0, 1'b0, 4'b0000, (k == 1) ? 4'b0011 : 4'b0010, 4'd0, 3'd1, 1'b1, 3'b000};
         checks++; if (obs() !== ev) begin failures++; $display("FAIL stuck_cyc%0d got=%h exp=%h", k, obs(), ev); end
         nxt();
      end
      #1;
`ifdef ISSUE_TIMEOUT_EN
      ev = {1'b0, 1'b0, 4'b0000, 4'b0000, 4'd1, 3'd1, 1'b0, 3'b100};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL timeout got=%h exp=%h", obs(), ev); end
      nxt(); req = 1; en = 4'b0011; rdy = 4'b0000;
      nxt(); req = 0; #1;
      ev = {1'b0, 1'b0, 4'b0000, 4'b0011, 4'd1, 3'd2, 1'b1, 3'b100};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL timeout_redispatch got=%h exp=%h", obs(), ev); end
`else
      for (int k = 0; k < 20; k++) nxt();
      #1;
      ev = {1'b0, 1'b0, 4'b0000, 4'b0010, 4'd0, 3'd1, 1'b1, 3'b000};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL no_timeout_wait got=%h exp=%h", obs(), ev); end
`endif
      rst_n = 0; #1;
      ev = '0;
      checks++; if (obs() !== ev) begin failures++; $display("FAIL reset_mid_dispatch got=%h exp=%h", obs(), ev); end
      rdy = 0; en = 0;
      nxt(); rst_n = 1; #1;
      checks++; if (obs() !== ev) begin failures++; $display("FAIL reset_release got=%h exp=%h", obs(), ev); end
      nxt(); req = 1; en = 4'b0001; rdy = 4'b0001; #1;
      ev = {1'b1, 1'b1, 4'b0001, 4'b0000, 4'd0, 3'd0, 1'b0, 3'b000};
      checks++; if (obs() !== ev) begin failures++; $display("FAIL reset_fresh_accept got=%h exp=%h", obs(), ev); end
      nxt(); req = 0;
      nxt();
   endtask

   // randomized traffic against a queue-based model of the issue/commit rules
   task automatic test_random();
      logic [3:0]  q [$];
      logic [3:0]  m_next, m_pend, e_en, e_vld, e_no;
      logic [2:0]  m_err, e_err, e_out;
      logic        m_busy, e_ack, e_agg, e_busy, acc;
      int          m_age;
      logic [20:0] ev;
      do_reset();
      q.delete();
      m_next = 0; m_pend = 0; m_err = 0; m_busy = 0; m_age = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (!req && $urandom_range(2) == 0) begin
            req = 1; en = 4'($urandom_range(15));
         end
         rdy      = 4'($urandom_range(15));
         agg_full = ($urandom_range(7) == 0);
         cm_req = 0; cm_no = 0;
         if (q.size() > 0 && $urandom_range(2) == 0) begin
            cm_req = 1;
            cm_no  = ($urandom_range(29) == 0) ? q[0] + 4'd1 : q[0];
         end else if (q.size() == 0 && $urandom_range(59) == 0) begin
            cm_req = 1; cm_no = 4'($urandom_range(15));
         end
         #1;
         e_no = m_next; e_out = 3'(q.size()); e_busy = m_busy; e_err = m_err;
         e_ack = 0; e_agg = 0; e_en = 0; e_vld = 0; acc = 0;
         if (!m_busy && req) begin
            if (en == 0) begin
               e_ack = 1; m_err[1] = 1;
            end else if (!agg_full && q.size() < BS) begin
               e_ack = 1; e_agg = 1; e_en = en; acc = 1;
            end
         end
         if (m_busy) begin
            e_vld  = m_pend;
            m_pend = m_pend & ~rdy;
            if (m_pend == 0) begin
               m_busy = 0; m_next = m_next + 4'd1;
            end else begin
`ifdef ISSUE_TIMEOUT_EN
               if (m_age == TO - 1) begin
                  m_busy = 0; m_next = m_next + 4'd1; m_err[2] = 1;
               end
`endif
               m_age++;
            end
         end
         if (cm_req) begin
            if (q.size() == 0) m_err[0] = 1;
            else if (q.pop_front() != cm_no) m_err[0] = 1;
         end
         if (acc) begin
            q.push_back(m_next); m_busy = 1; m_pend = en; m_age = 0;
         end
         ev = {e_ack, e_agg, e_en, e_vld, e_no, e_out, e_busy, e_err};
         checks++; if (obs() !== ev) begin failures++; $display("FAIL rand_cyc%0d got=%h exp=%h", cyc, obs(), ev); end
         nxt();
         if (e_ack) req = 0;
      end
      req = 0; cm_req = 0;
   endtask

   initial begin
      test_reset();
      test_all_ready();
      test_staggered();
      test_credit();
      test_same_cycle_and_order();
      test_empty_mask();
      test_stuck_and_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench time limit");
   end

endmodule
